// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: default words, FSM state codes, IF/ID payload.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_HALT_WORD = 32'h0000_000C;
  localparam logic [XLEN-1:0] DEF_NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  // Word-align a fetch address by dropping the byte-offset bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new payload, insert a bubble, or hold.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t din,
  output ifid_t dout
);

  ifid_t bubble_val;

  always_comb begin
    bubble_val       = '0;
    bubble_val.instr = NOP_WORD;
  end

  // Bubble wins over load; neither asserted means hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= bubble_val;
    end else if (bubble) begin
      dout <= bubble_val;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, BOOT/RUN/HALT control, fetch counter.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] HALT_WORD = DEF_HALT_WORD,
  parameter logic [XLEN-1:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] iaddr_o,
  input  logic [XLEN-1:0] idata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o,
  output logic            halted_o,
  output logic            addr_err_o,
  output logic [XLEN-1:0] fetch_cnt_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            addr_err_d;
  logic            halted_d;
  logic            ifid_load, ifid_bubble;
  logic [XLEN-1:0] pc_plus4;
  ifid_t           ifid_din, ifid_q;

  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    ifid_din       = '0;
    ifid_din.valid = 1'b1;
    ifid_din.instr = idata_i;
    ifid_din.pc    = pc_q;
    ifid_din.pc4   = pc_plus4;
  end

  // State, PC, counter and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      addr_err_o <= 1'b0;
      halted_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      addr_err_o <= addr_err_d;
      halted_o   <= halted_d;
    end
  end

  // Next-state and datapath control; redirect > stall > flush/normal in RUN.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    addr_err_d  = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = ST_RUN;
      end

      ST_RUN: begin
        if (redirect_i) begin
          pc_d        = align_pc(redirect_pc_i);
          ifid_bubble = 1'b1;
          addr_err_d  = |redirect_pc_i[1:0];
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (flush_i) begin
          pc_d        = pc_plus4;
          ifid_bubble = 1'b1;
        end else begin
          ifid_load = 1'b1;
          cnt_d     = cnt_q + XLEN'(1);
          if (idata_i == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      ST_HALT: begin
        ifid_bubble = 1'b1;
        if (redirect_i) begin
          pc_d       = align_pc(redirect_pc_i);
          addr_err_d = |redirect_pc_i[1:0];
          state_d    = ST_RUN;
        end
      end

      default: begin
        ifid_bubble = 1'b1;
        state_d     = ST_BOOT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .bubble(ifid_bubble),
    .din   (ifid_din),
    .dout  (ifid_q)
  );

  assign iaddr_o     = pc_q;
  assign id_valid_o  = ifid_q.valid;
  assign id_instr_o  = ifid_q.instr;
  assign id_pc_o     = ifid_q.pc;
  assign id_pc4_o    = ifid_q.pc4;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small combinational imem model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] iaddr_o, idata_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o, id_pc_o, id_pc4_o;
  logic        halted_o, addr_err_o;
  logic [31:0] fetch_cnt_o;

  logic [31:0] imem [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign idata_i = imem[iaddr_o[6:2]];

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .iaddr_o      (iaddr_o),
    .idata_i      (idata_i),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_pc4_o     (id_pc4_o),
    .halted_o     (halted_o),
    .addr_err_o   (addr_err_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = tgt;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'h1000_0000 + 32'(i);
    imem[5] = 32'h0000_000C;

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rst_iaddr", iaddr_o, 32'h0);
    check("rst_valid", 32'(id_valid_o), 32'h0);
    check("rst_instr", id_instr_o, 32'h0);
    check("rst_halted", 32'(halted_o), 32'h0);
    check("rst_cnt", fetch_cnt_o, 32'h0);

    // Boot bubble, then sequential fetches.
    rst = 1'b1;
    step();
    check("boot_valid", 32'(id_valid_o), 32'h0);
    check("boot_iaddr", iaddr_o, 32'h0);
    step();
    check("f0_valid", 32'(id_valid_o), 32'h1);
    check("f0_pc", id_pc_o, 32'h0);
    check("f0_instr", id_instr_o, 32'h1000_0000);
    check("f0_pc4", id_pc4_o, 32'h4);
    check("f0_cnt", fetch_cnt_o, 32'h1);
    step();
    check("f1_pc", id_pc_o, 32'h4);
    check("f1_iaddr", iaddr_o, 32'h8);

    // Stall two cycles at PC=8.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_iaddr", iaddr_o, 32'h8);
      check("stall_pc", id_pc_o, 32'h4);
      check("stall_cnt", fetch_cnt_o, 32'h2);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("f2_pc", id_pc_o, 32'h8);
    check("f2_cnt", fetch_cnt_o, 32'h3);

    // Redirect overrides stall.
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    step();
    check("rd_iaddr", iaddr_o, 32'h40);
    check("rd_valid", 32'(id_valid_o), 32'h0);
    check("rd_cnt", fetch_cnt_o, 32'h3);
    check("rd_aerr", 32'(addr_err_o), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rdt_pc", id_pc_o, 32'h40);
    check("rdt_instr", id_instr_o, 32'h1000_0010);
    check("rdt_cnt", fetch_cnt_o, 32'h4);

    // Flush at PC=0x10.
    drive(1'b0, 1'b0, 1'b1, 32'h10);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("fl_valid", 32'(id_valid_o), 32'h0);
    check("fl_iaddr", iaddr_o, 32'h14);
    check("fl_cnt", fetch_cnt_o, 32'h4);

    // Halt word at 0x14.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("h_pc", id_pc_o, 32'h14);
    check("h_valid", 32'(id_valid_o), 32'h1);
    check("h_instr", id_instr_o, 32'h0000_000C);
    check("h_halted", 32'(halted_o), 32'h1);
    check("h_iaddr", iaddr_o, 32'h14);
    check("h_cnt", fetch_cnt_o, 32'h5);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("hb_valid", 32'(id_valid_o), 32'h0);
    check("hb_halted", 32'(halted_o), 32'h1);
    check("hb_iaddr", iaddr_o, 32'h14);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    check("hx_halted", 32'(halted_o), 32'h0);
    check("hx_iaddr", iaddr_o, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("hx_pc", id_pc_o, 32'h0);
    check("hx_cnt", fetch_cnt_o, 32'h6);

    // Misaligned redirect.
    drive(1'b0, 1'b0, 1'b1, 32'h1E);
    step();
    check("ae_iaddr", iaddr_o, 32'h1C);
    check("ae_pulse", 32'(addr_err_o), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("ae_clear", 32'(addr_err_o), 32'h0);
    check("ae_pc", id_pc_o, 32'h1C);
    check("ae_instr", id_instr_o, 32'h1000_0007);
    check("ae_cnt", fetch_cnt_o, 32'h7);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    check("wr_iaddr", iaddr_o, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("wr_next", iaddr_o, 32'h0);
    check("wr_pc", id_pc_o, 32'hFFFF_FFFC);
    check("wr_pc4", id_pc4_o, 32'h0);

    // Asynchronous reset mid-run, then a fresh boot.
    #1 rst = 1'b0;
    #1;
    check("ar_valid", 32'(id_valid_o), 32'h0);
    check("ar_cnt", fetch_cnt_o, 32'h0);
    check("ar_iaddr", iaddr_o, 32'h0);
    check("ar_pc4", id_pc4_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rb_valid", 32'(id_valid_o), 32'h0);
    step();
    check("rb_pc_valid", 32'(id_valid_o), 32'h1);
    check("rb_cnt", fetch_cnt_o, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
